// File: rtl/rc_ring_out_arb_if.sv
// rc_ring_out_arb_if: opcode type and port bundle for the ring-output arbiter
package rc_ring_pkg;
    typedef logic [3:0] t_opcode;
endpackage

interface rc_ring_out_arb_if;
    import rc_ring_pkg::*;
    logic        PassValidQ501H;
    logic [9:0]  PassRequestorQ501H;
    t_opcode     PassOpcodeQ501H;
    logic [31:0] PassAddressQ501H;
    logic [31:0] PassDataQ501H;
    logic        F2cRspValidQ501H;
    logic [9:0]  F2cRspRequestorQ501H;
    t_opcode     F2cRspOpcodeQ501H;
    logic [31:0] F2cRspAddressQ501H;
    logic [31:0] F2cRspDataQ501H;
    logic        C2fReqValidQ501H;
    logic [9:0]  C2fReqRequestorQ501H;
    t_opcode     C2fReqOpcodeQ501H;
    logic [31:0] C2fReqAddressQ501H;
    logic [31:0] C2fReqDataQ501H;
    logic [1:0]  SelRingOutQ501H;
    logic        F2cGntQ501H;
    logic        C2fGntQ501H;
    logic        RingOutValidQ502H;
    logic [9:0]  RingOutRequestorQ502H;
    t_opcode     RingOutOpcodeQ502H;
    logic [31:0] RingOutAddressQ502H;
    logic [31:0] RingOutDataQ502H;
    logic        StarveQ501H;
    logic [7:0]  StarveCntQ501H;

    modport master (
        output PassValidQ501H, PassRequestorQ501H, PassOpcodeQ501H, PassAddressQ501H, PassDataQ501H,
        output F2cRspValidQ501H, F2cRspRequestorQ501H, F2cRspOpcodeQ501H, F2cRspAddressQ501H, F2cRspDataQ501H,
        output C2fReqValidQ501H, C2fReqRequestorQ501H, C2fReqOpcodeQ501H, C2fReqAddressQ501H, C2fReqDataQ501H,
        input  SelRingOutQ501H, F2cGntQ501H, C2fGntQ501H,
        input  RingOutValidQ502H, RingOutRequestorQ502H, RingOutOpcodeQ502H, RingOutAddressQ502H, RingOutDataQ502H,
        input  StarveQ501H, StarveCntQ501H
    );

    modport slave (
        input  PassValidQ501H, PassRequestorQ501H, PassOpcodeQ501H, PassAddressQ501H, PassDataQ501H,
        input  F2cRspValidQ501H, F2cRspRequestorQ501H, F2cRspOpcodeQ501H, F2cRspAddressQ501H, F2cRspDataQ501H,
        input  C2fReqValidQ501H, C2fReqRequestorQ501H, C2fReqOpcodeQ501H, C2fReqAddressQ501H, C2fReqDataQ501H,
        output SelRingOutQ501H, F2cGntQ501H, C2fGntQ501H,
        output RingOutValidQ502H, RingOutRequestorQ502H, RingOutOpcodeQ502H, RingOutAddressQ502H, RingOutDataQ502H,
        output StarveQ501H, StarveCntQ501H
    );
endinterface

// File: rtl/rc_ring_out_arb.sv
// rc_ring_out_arb: picks pass-through / F2C response / C2F request for the ring slot and registers it
module rc_ring_out_arb #(
    parameter int unsigned STARVE_TH = 16
) (
    input logic QClk,
    input logic RstQnnnH,
    rc_ring_out_arb_if.slave ring
);
    import rc_ring_pkg::*;

    typedef enum logic [1:0] {SEL_BUBBLE, SEL_PASS, SEL_F2C, SEL_C2F} t_sel;

    localparam logic [7:0] STARVE_TH8 = 8'(STARVE_TH);

    t_sel        sel;
    logic        lastLocal;
    logic        localValid;
    logic        localGnt;
    logic [7:0]  starveCnt;
    logic [9:0]  nxtRequestor;
    t_opcode     nxtOpcode;
    logic [31:0] nxtAddress;
    logic [31:0] nxtData;
    logic        outValid;
    logic [9:0]  outRequestor;
    t_opcode     outOpcode;
    logic [31:0] outAddress;
    logic [31:0] outData;

    // Pass-through always wins; otherwise F2C wins unless C2F is valid and F2C went last
    always_comb begin
        sel = SEL_BUBBLE;
        if (ring.PassValidQ501H)
            sel = SEL_PASS;
        else if (ring.F2cRspValidQ501H && (!ring.C2fReqValidQ501H || lastLocal))
            sel = SEL_F2C;
        else if (ring.C2fReqValidQ501H)
            sel = SEL_C2F;
    end

    // Winner's fields, zeroed on a bubble so nothing stale reaches the ring
    always_comb begin
        nxtRequestor = sel == SEL_PASS ? ring.PassRequestorQ501H :
                       sel == SEL_F2C  ? ring.F2cRspRequestorQ501H :
                       sel == SEL_C2F  ? ring.C2fReqRequestorQ501H : '0;
        nxtOpcode    = sel == SEL_PASS ? ring.PassOpcodeQ501H :
                       sel == SEL_F2C  ? ring.F2cRspOpcodeQ501H :
                       sel == SEL_C2F  ? ring.C2fReqOpcodeQ501H : '0;
        nxtAddress   = sel == SEL_PASS ? ring.PassAddressQ501H :
                       sel == SEL_F2C  ? ring.F2cRspAddressQ501H :
                       sel == SEL_C2F  ? ring.C2fReqAddressQ501H : '0;
        nxtData      = sel == SEL_PASS ? ring.PassDataQ501H :
                       sel == SEL_F2C  ? ring.F2cRspDataQ501H :
                       sel == SEL_C2F  ? ring.C2fReqDataQ501H : '0;
    end

    assign localValid            = ring.F2cRspValidQ501H | ring.C2fReqValidQ501H;
    assign localGnt              = (sel == SEL_F2C) | (sel == SEL_C2F);
    assign ring.SelRingOutQ501H  = sel;
    assign ring.F2cGntQ501H      = sel == SEL_F2C;
    assign ring.C2fGntQ501H      = sel == SEL_C2F;
    assign ring.StarveCntQ501H   = starveCnt;
    assign ring.StarveQ501H      = starveCnt >= STARVE_TH8;

    // Round-robin pointer remembers which local source was granted last
    always_ff @(posedge QClk) begin
        if (RstQnnnH)
            lastLocal <= 1'b1;
        else if (localGnt)
            lastLocal <= sel == SEL_C2F;
    end

    // Consecutive cycles a pending local source went without a grant, saturating
    always_ff @(posedge QClk) begin
        if (RstQnnnH || localGnt || !localValid)
            starveCnt <= '0;
        else if (starveCnt != 8'hff)
            starveCnt <= starveCnt + 8'd1;
    end

    // Ring output slot, one cycle behind selection
    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            outValid     <= 1'b0;
            outRequestor <= '0;
            outOpcode    <= '0;
            outAddress   <= '0;
            outData      <= '0;
        end else begin
            outValid     <= sel != SEL_BUBBLE;
            outRequestor <= nxtRequestor;
            outOpcode    <= nxtOpcode;
            outAddress   <= nxtAddress;
            outData      <= nxtData;
        end
    end

    assign ring.RingOutValidQ502H     = outValid;
    assign ring.RingOutRequestorQ502H = outRequestor;
    assign ring.RingOutOpcodeQ502H    = outOpcode;
    assign ring.RingOutAddressQ502H   = outAddress;
    assign ring.RingOutDataQ502H      = outData;
endmodule

// File: tb/tb_rc_ring_out_arb.sv
// tb_rc_ring_out_arb: scoreboard bench for the ring-output arbiter
module tb_rc_ring_out_arb;
    import rc_ring_pkg::*;

    localparam int unsigned TH = 16;

    typedef struct packed {
        logic        valid;
        logic [9:0]  req;
        t_opcode     op;
        logic [31:0] addr;
        logic [31:0] data;
    } t_pkt;

    logic QClk;
    logic RstQnnnH;
    int   errors = 0;
    int   checks = 0;
    t_pkt expQ[$];

    rc_ring_out_arb_if ring();

    rc_ring_out_arb #(.STARVE_TH(TH)) dut (
        .QClk(QClk),
        .RstQnnnH(RstQnnnH),
        .ring(ring)
    );

    initial QClk = 1'b0;
    always #5 QClk = ~QClk;

    task automatic tick();
        @(posedge QClk);
        #1;
    endtask

    task automatic setIn(input logic pv, input logic fv, input logic cv);
        ring.PassValidQ501H       = pv;
        ring.PassRequestorQ501H   = 10'($urandom);
        ring.PassOpcodeQ501H      = t_opcode'($urandom);
        ring.PassAddressQ501H     = $urandom;
        ring.PassDataQ501H        = $urandom;
        ring.F2cRspValidQ501H     = fv;
        ring.F2cRspRequestorQ501H = 10'($urandom);
        ring.F2cRspOpcodeQ501H    = t_opcode'($urandom);
        ring.F2cRspAddressQ501H   = $urandom;
        ring.F2cRspDataQ501H      = $urandom;
        ring.C2fReqValidQ501H     = cv;
        ring.C2fReqRequestorQ501H = 10'($urandom);
        ring.C2fReqOpcodeQ501H    = t_opcode'($urandom);
        ring.C2fReqAddressQ501H   = $urandom;
        ring.C2fReqDataQ501H      = $urandom;
    endtask

    function automatic t_pkt winner(input logic [1:0] s);
        return s == 2'd1 ? {1'b1, ring.PassRequestorQ501H, ring.PassOpcodeQ501H, ring.PassAddressQ501H, ring.PassDataQ501H} :
               s == 2'd2 ? {1'b1, ring.F2cRspRequestorQ501H, ring.F2cRspOpcodeQ501H, ring.F2cRspAddressQ501H, ring.F2cRspDataQ501H} :
               s == 2'd3 ? {1'b1, ring.C2fReqRequestorQ501H, ring.C2fReqOpcodeQ501H, ring.C2fReqAddressQ501H, ring.C2fReqDataQ501H} :
               '0;
    endfunction

    function automatic t_pkt getOut();
        return {ring.RingOutValidQ502H, ring.RingOutRequestorQ502H, ring.RingOutOpcodeQ502H,
                ring.RingOutAddressQ502H, ring.RingOutDataQ502H};
    endfunction

    task automatic doReset();
        RstQnnnH = 1'b1;
        setIn(1'b0, 1'b0, 1'b0);
        tick();
        RstQnnnH = 1'b0;
        expQ.delete();
    endtask

    task automatic test_reset();
        t_pkt got;
        RstQnnnH = 1'b1;
        setIn(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        RstQnnnH = 1'b0;
        #1;
        got = getOut();
        checks++; if (got !== t_pkt'(0)) begin errors++; $display("FAIL reset_out got=%h exp=0", got); end
        checks++; if (ring.SelRingOutQ501H !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", ring.SelRingOutQ501H); end
        checks++; if (ring.StarveCntQ501H !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", ring.StarveCntQ501H); end
        checks++; if (ring.StarveQ501H !== 1'b0) begin errors++; $display("FAIL reset_starve got=%b exp=0", ring.StarveQ501H); end
        tick();
        checks++; if (ring.RingOutValidQ502H !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", ring.RingOutValidQ502H); end
    endtask

    task automatic test_single_c2f();
        t_pkt got, exp;
        doReset();
        setIn(1'b0, 1'b0, 1'b1);
        ring.C2fReqAddressQ501H = 32'h0200_0010;
        ring.C2fReqDataQ501H    = 32'hDEAD_BEEF;
        #1;
        checks++; if (ring.SelRingOutQ501H !== 2'd3) begin errors++; $display("FAIL c2f_sel got=%0d exp=3", ring.SelRingOutQ501H); end
        checks++; if ({ring.F2cGntQ501H, ring.C2fGntQ501H} !== 2'b01) begin errors++; $display("FAIL c2f_gnt got=%b exp=01", {ring.F2cGntQ501H, ring.C2fGntQ501H}); end
        expQ.push_back(winner(2'd3));
        tick();
        got = getOut();
        exp = expQ.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL c2f_out got=%h exp=%h", got, exp); end
        checks++; if (ring.RingOutAddressQ502H !== 32'h0200_0010 || ring.RingOutDataQ502H !== 32'hDEAD_BEEF)
            begin errors++; $display("FAIL c2f_fields got=%h/%h exp=02000010/deadbeef", ring.RingOutAddressQ502H, ring.RingOutDataQ502H); end
        setIn(1'b0, 1'b1, 1'b1);
        #1;
        checks++; if (ring.SelRingOutQ501H !== 2'd2) begin errors++; $display("FAIL c2f_ptr got=%0d exp=2", ring.SelRingOutQ501H); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] seq [4] = '{2'd2, 2'd3, 2'd2, 2'd3};
        t_pkt got, exp;
        doReset();
        for (int i = 0; i < 4; i++) begin
            setIn(1'b0, 1'b1, 1'b1);
            #1;
            checks++; if (ring.SelRingOutQ501H !== seq[i]) begin errors++; $display("FAIL rr_sel[%0d] got=%0d exp=%0d", i, ring.SelRingOutQ501H, seq[i]); end
            checks++; if ({ring.F2cGntQ501H, ring.C2fGntQ501H} !== {seq[i] == 2'd2, seq[i] == 2'd3})
                begin errors++; $display("FAIL rr_gnt[%0d] got=%b", i, {ring.F2cGntQ501H, ring.C2fGntQ501H}); end
            expQ.push_back(winner(seq[i]));
            tick();
            got = getOut();
            exp = expQ.pop_front();
            checks++; if (got !== exp) begin errors++; $display("FAIL rr_out[%0d] got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_all_valid();
        doReset();
        setIn(1'b1, 1'b1, 1'b1);
        #1;
        checks++; if (ring.SelRingOutQ501H !== 2'd1 || ring.F2cGntQ501H !== 1'b0 || ring.C2fGntQ501H !== 1'b0)
            begin errors++; $display("FAIL all_sel got=%0d gnt=%b%b exp=1 gnt=00", ring.SelRingOutQ501H, ring.F2cGntQ501H, ring.C2fGntQ501H); end
        tick();
        checks++; if (ring.StarveCntQ501H !== 8'd1) begin errors++; $display("FAIL all_cnt got=%0d exp=1", ring.StarveCntQ501H); end
        setIn(1'b0, 1'b1, 1'b1);
        #1;
        checks++; if (ring.SelRingOutQ501H !== 2'd2) begin errors++; $display("FAIL all_ptr got=%0d exp=2", ring.SelRingOutQ501H); end
        tick();
    endtask

    task automatic test_starve();
        t_pkt got, exp;
        doReset();
        for (int i = 0; i < 20; i++) begin
            setIn(1'b1, 1'b1, 1'b0);
            #1;
            checks++; if (ring.SelRingOutQ501H !== 2'd1 || ring.F2cGntQ501H !== 1'b0)
                begin errors++; $display("FAIL starve_sel[%0d] got=%0d gnt=%b exp=1 gnt=0", i, ring.SelRingOutQ501H, ring.F2cGntQ501H); end
            expQ.push_back(winner(2'd1));
            tick();
            got = getOut();
            exp = expQ.pop_front();
            checks++; if (got !== exp) begin errors++; $display("FAIL starve_out[%0d] got=%h exp=%h", i, got, exp); end
            checks++; if (ring.StarveCntQ501H !== 8'(i + 1)) begin errors++; $display("FAIL starve_cnt[%0d] got=%0d exp=%0d", i, ring.StarveCntQ501H, i + 1); end
            checks++; if (ring.StarveQ501H !== ((i + 1) >= TH)) begin errors++; $display("FAIL starve_flag[%0d] got=%b exp=%b", i, ring.StarveQ501H, (i + 1) >= TH); end
        end
        setIn(1'b0, 1'b1, 1'b0);
        #1;
        checks++; if (ring.F2cGntQ501H !== 1'b1) begin errors++; $display("FAIL starve_release got=%b exp=1", ring.F2cGntQ501H); end
        expQ.push_back(winner(2'd2));
        tick();
        got = getOut();
        exp = expQ.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL starve_rel_out got=%h exp=%h", got, exp); end
        checks++; if (ring.StarveCntQ501H !== 8'd0 || ring.StarveQ501H !== 1'b0)
            begin errors++; $display("FAIL starve_clear got=%0d/%b exp=0/0", ring.StarveCntQ501H, ring.StarveQ501H); end
    endtask

    task automatic test_reset_mid();
        t_pkt got, exp;
        doReset();
        setIn(1'b1, 1'b0, 1'b0);
        #1;
        expQ.push_back(winner(2'd1));
        tick();
        got = getOut();
        exp = expQ.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL mid_pre got=%h exp=%h", got, exp); end
        RstQnnnH = 1'b1;
        setIn(1'b1, 1'b1, 1'b0);
        #1;
        checks++; if (ring.SelRingOutQ501H !== 2'd1) begin errors++; $display("FAIL mid_comb_sel got=%0d exp=1", ring.SelRingOutQ501H); end
        tick();
        RstQnnnH = 1'b0;
        got = getOut();
        checks++; if (got !== t_pkt'(0)) begin errors++; $display("FAIL mid_out got=%h exp=0", got); end
        checks++; if (ring.StarveCntQ501H !== 8'd0) begin errors++; $display("FAIL mid_cnt got=%0d exp=0", ring.StarveCntQ501H); end
        setIn(1'b0, 1'b1, 1'b1);
        #1;
        checks++; if (ring.SelRingOutQ501H !== 2'd2) begin errors++; $display("FAIL mid_ptr got=%0d exp=2", ring.SelRingOutQ501H); end
        tick();
    endtask

    task automatic test_saturate();
        int expCnt;
        doReset();
        for (int i = 0; i < 300; i++) begin
            setIn(1'b1, 1'b0, 1'b1);
            tick();
            expCnt = (i + 1) > 255 ? 255 : i + 1;
            checks++; if (ring.StarveCntQ501H !== 8'(expCnt)) begin errors++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, ring.StarveCntQ501H, expCnt); end
        end
        checks++; if (ring.StarveQ501H !== 1'b1) begin errors++; $display("FAIL sat_flag got=%b exp=1", ring.StarveQ501H); end
    endtask

    task automatic test_back_to_back();
        t_pkt got, exp;
        logic [1:0] seq [5] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
        logic [2:0] vld [5] = '{3'b010, 3'b010, 3'b010, 3'b001, 3'b000};
        doReset();
        for (int i = 0; i < 5; i++) begin
            setIn(vld[i][2], vld[i][1], vld[i][0]);
            #1;
            checks++; if (ring.SelRingOutQ501H !== seq[i]) begin errors++; $display("FAIL b2b_sel[%0d] got=%0d exp=%0d", i, ring.SelRingOutQ501H, seq[i]); end
            expQ.push_back(winner(seq[i]));
            tick();
            got = getOut();
            exp = expQ.pop_front();
            checks++; if (got !== exp) begin errors++; $display("FAIL b2b_out[%0d] got=%h exp=%h", i, got, exp); end
            checks++; if (ring.StarveCntQ501H !== 8'd0) begin errors++; $display("FAIL b2b_cnt[%0d] got=%0d exp=0", i, ring.StarveCntQ501H); end
        end
    endtask

    initial begin
        RstQnnnH = 1'b1;
        setIn(1'b0, 1'b0, 1'b0);
        test_reset();
        test_single_c2f();
        test_round_robin();
        test_all_valid();
        test_starve();
        test_reset_mid();
        test_saturate();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
